// File: rtl/button_press_decoder_pkg.sv
// Shared alarm-clock definitions: button decoder state encoding and default
// 100 MHz timing constants reused by the time-set logic.
package button_press_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } btn_state_t;

  localparam int unsigned DEF_LONG_PRESS_CYCLES = 100_000_000;  // 1 s
  localparam int unsigned DEF_REPEAT_CYCLES     = 20_000_000;   // 200 ms
  localparam int unsigned DEF_CNT_WIDTH         = 27;

  function automatic logic is_active(input btn_state_t s);
    return (s == ST_PRESSED) || (s == ST_LONG_HELD);
  endfunction

endpackage

// File: rtl/button_press_decoder.sv
// Turns a debounced button level into press/release/short/long/repeat pulses.
// All outputs registered, one cycle after the sampling edge; no backpressure.
module button_press_decoder
  import button_press_decoder_pkg::*;
#(
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_WIDTH         = DEF_CNT_WIDTH
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Enable,
  input  logic i_Signal,
  output logic o_Press,
  output logic o_Release,
  output logic o_Short,
  output logic o_Long,
  output logic o_Repeat,
  output logic o_Held
);

  localparam logic [CNT_WIDTH-1:0] LP_MAX = CNT_WIDTH'(LONG_PRESS_CYCLES);
  localparam logic [CNT_WIDTH-1:0] RP_MAX = CNT_WIDTH'(REPEAT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

  btn_state_t           r_state;
  logic                 r_prev;
  logic [CNT_WIDTH-1:0] r_hold_cnt;
  logic [CNT_WIDTH-1:0] r_rep_cnt;
  logic                 r_press, r_release, r_short, r_long, r_repeat, r_held;

  btn_state_t           w_state_nxt;
  logic [CNT_WIDTH-1:0] w_hold_nxt;
  logic [CNT_WIDTH-1:0] w_rep_nxt;
  logic [CNT_WIDTH-1:0] w_hold_inc;
  logic [CNT_WIDTH-1:0] w_rep_inc;
  logic                 w_rise;
  logic                 w_press, w_release, w_short, w_long, w_repeat, w_held;

  assign w_rise     = i_Signal & ~r_prev;
  assign w_hold_inc = r_hold_cnt + ONE;
  assign w_rep_inc  = r_rep_cnt + ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_rep_nxt   = r_rep_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    if (!i_Enable) begin
      w_state_nxt = ST_IDLE;
      w_hold_nxt  = '0;
      w_rep_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt = ST_PRESSED;
            w_hold_nxt  = ONE;
            w_rep_nxt   = '0;
            w_press     = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (i_Signal) begin
            // The counter leaves PRESSED on reaching LP_MAX, so it never wraps.
            w_hold_nxt = w_hold_inc;
            if (w_hold_inc == LP_MAX) begin
              w_state_nxt = ST_LONG_HELD;
              w_rep_nxt   = '0;
              w_long      = 1'b1;
              w_repeat    = 1'b1;
            end
          end else begin
            w_state_nxt = ST_IDLE;
            w_hold_nxt  = '0;
            w_release   = 1'b1;
            w_short     = 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (i_Signal) begin
            if (w_rep_inc == RP_MAX) begin
              w_rep_nxt = '0;
              w_repeat  = 1'b1;
            end else begin
              w_rep_nxt = w_rep_inc;
            end
          end else begin
            w_state_nxt = ST_IDLE;
            w_hold_nxt  = '0;
            w_rep_nxt   = '0;
            w_release   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_hold_nxt  = '0;
          w_rep_nxt   = '0;
        end
      endcase
    end
    w_held = is_active(w_state_nxt);
  end

  // r_prev resets high so a button held through reset is not seen as a press.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state    <= ST_IDLE;
      r_prev     <= 1'b1;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev     <= i_Signal;
      r_hold_cnt <= w_hold_nxt;
      r_rep_cnt  <= w_rep_nxt;
      r_press    <= w_press;
      r_release  <= w_release;
      r_short    <= w_short;
      r_long     <= w_long;
      r_repeat   <= w_repeat;
      r_held     <= w_held;
    end
  end

  assign o_Press   = r_press;
  assign o_Release = r_release;
  assign o_Short   = r_short;
  assign o_Long    = r_long;
  assign o_Repeat  = r_repeat;
  assign o_Held    = r_held;

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed bench for button_press_decoder with LONG=10, REPEAT=4 at 100 MHz.
module tb_button_press_decoder;

  localparam int LONG = 10;
  localparam int REP  = 4;

  logic i_Clk = 1'b0;
  logic i_Rst_L, i_Enable, i_Signal;
  logic o_Press, o_Release, o_Short, o_Long, o_Repeat, o_Held;
  logic [5:0] w_obs;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rep_seen, n_long_seen;

  always #5 i_Clk = ~i_Clk;

  button_press_decoder #(
    .LONG_PRESS_CYCLES(LONG),
    .REPEAT_CYCLES    (REP),
    .CNT_WIDTH        (27)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_Enable (i_Enable),
    .i_Signal (i_Signal),
    .o_Press  (o_Press),
    .o_Release(o_Release),
    .o_Short  (o_Short),
    .o_Long   (o_Long),
    .o_Repeat (o_Repeat),
    .o_Held   (o_Held)
  );

  // {press, release, short, long, repeat, held}
  assign w_obs = {o_Press, o_Release, o_Short, o_Long, o_Repeat, o_Held};

  task automatic check(input logic [5:0] obs, input logic [5:0] exp, input string tag);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input int obs, input int exp, input string tag);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one input level, clock it, and check the registered result.
  task automatic tick(input logic sig, input logic [5:0] exp, input string tag);
    i_Signal = sig;
    @(posedge i_Clk);
    #1;
    n_rep_seen  += int'(o_Repeat);
    n_long_seen += int'(o_Long);
    check(w_obs, exp, tag);
  endtask

  task automatic hold_to(input int n, input string tag);
    logic [5:0] e;
    n_rep_seen  = 0;
    n_long_seen = 0;
    for (int h = 1; h <= n; h++) begin
      e = 6'b000001;
      if (h == 1) e[5] = 1'b1;
      if (h == LONG) e[2] = 1'b1;
      if (h >= LONG && ((h - LONG) % REP) == 0) e[1] = 1'b1;
      tick(1'b1, e, $sformatf("%s_h%0d", tag, h));
    end
  endtask

  task automatic press_hold(input int n, input string tag);
    logic [5:0] e;
    hold_to(n, tag);
    e = 6'b010000;
    if (n < LONG) e[3] = 1'b1;
    tick(1'b0, e, {tag, "_rel"});
    tick(1'b0, 6'b000000, {tag, "_idle"});
  endtask

  initial begin
    i_Rst_L  = 1'b0;
    i_Enable = 1'b1;
    i_Signal = 1'b0;
    #3;
    check(w_obs, 6'b000000, "reset_state");
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    tick(1'b0, 6'b000000, "idle0");
    tick(1'b0, 6'b000000, "idle1");

    press_hold(3, "h3");
    press_hold(9, "h9");
    check_int(n_long_seen, 0, "h9_long_count");
    press_hold(10, "h10");
    check_int(n_long_seen, 1, "h10_long_count");
    press_hold(25, "h25");
    check_int(n_long_seen, 1, "h25_long_count");
    check_int(n_rep_seen, 4, "h25_repeat_count");

    // Reset mid-hold clears outputs without a clock edge.
    hold_to(6, "rst");
    i_Rst_L = 1'b0;
    #1;
    check(w_obs, 6'b000000, "rst_async");
    tick(1'b1, 6'b000000, "rst_low0");
    tick(1'b1, 6'b000000, "rst_low1");
    i_Rst_L = 1'b1;
    tick(1'b1, 6'b000000, "rst_held0");
    tick(1'b1, 6'b000000, "rst_held1");
    tick(1'b1, 6'b000000, "rst_held2");
    tick(1'b0, 6'b000000, "rst_rel");
    tick(1'b0, 6'b000000, "rst_idle");
    press_hold(2, "rst_fresh");

    // Disable mid-hold, re-enable while still held.
    hold_to(5, "en");
    i_Enable = 1'b0;
    tick(1'b1, 6'b000000, "en_dis_h6");
    tick(1'b1, 6'b000000, "en_dis_h7");
    i_Enable = 1'b1;
    tick(1'b1, 6'b000000, "en_re_h8");
    tick(1'b1, 6'b000000, "en_re_h9");
    tick(1'b1, 6'b000000, "en_re_h10");
    tick(1'b0, 6'b000000, "en_rel");
    tick(1'b0, 6'b000000, "en_idle");
    press_hold(3, "en_fresh");

    // Single-cycle pulse.
    tick(1'b1, 6'b100001, "pulse_press");
    tick(1'b0, 6'b011000, "pulse_rel");
    tick(1'b0, 6'b000000, "pulse_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
